// File: rtl/cobra_hex_display.sv
// Eight-digit multiplexed hex display for the CYBERcobra output word.
// The word is latched once per frame so a digit never shows a half-updated value.
module cobra_hex_display #(
  parameter int DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic        hold_i,
  input  logic        blank_i,
  input  logic [7:0]  dp_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [31:0]   sh;
  logic          init;

  logic          slot_end;
  logic          frame_wrap;
  logic [4:0]    shamt;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          blank_d;
  logic [7:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] encode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end   = (pre == PRE_MAX);
  assign frame_wrap = slot_end && (idx == 3'd7);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pre  <= '0;
      idx  <= '0;
      sh   <= '0;
      init <= 1'b1;
    end else begin
      pre <= slot_end ? '0 : pre + PW'(1);
      if (slot_end) idx <= idx + 3'd1;
      // The first cycle after reset always captures, otherwise only at a frame boundary.
      if (init) begin
        sh   <= data_i;
        init <= 1'b0;
      end else if (frame_wrap && !hold_i) begin
        sh <= data_i;
      end
    end
  end

  always_comb begin
    shamt   = {idx, 2'b00};
    nib     = sh[shamt +: 4];
    upper   = sh >> shamt;
    blank_d = blank_i && (idx != 3'd0) && (upper == 32'd0);
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (!blank_d) begin
      an_d  = ~(8'd1 << idx);
      seg_d = encode(nib);
      dp_d  = ~dp_i[idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      an_o  <= 8'hFF;
      seg_o <= 7'h7F;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= an_d;
      seg_o <= seg_d;
      dp_o  <= dp_d;
    end
  end

endmodule

// File: tb/tb_cobra_hex_display.sv
// Self-checking bench for cobra_hex_display with a cycle-count reference model
// and a scoreboard queue of expected {an, seg, dp} words.
module tb_cobra_hex_display;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk;
  logic        rst_i;
  logic [31:0] data_i;
  logic        hold_i;
  logic        blank_i;
  logic [7:0]  dp_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;

  int checks = 0;
  int errors = 0;

  // Reference model state: edges since reset release and the latched word.
  int          m_e = 0;
  logic [31:0] m_sh = '0;
  logic [15:0] exp_q[$];
  string       phase = "reset";

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  cobra_hex_display #(.DIV(DIV)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .data_i (data_i),
    .hold_i (hold_i),
    .blank_i(blank_i),
    .dp_i   (dp_i),
    .an_o   (an_o),
    .seg_o  (seg_o),
    .dp_o   (dp_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx();
    return (m_e / DIV) % 8;
  endfunction

  // One clock: predict, step the model, let the edge happen, compare at the negedge.
  task automatic tick();
    int          d;
    logic [31:0] rest;
    logic [3:0]  n;
    logic [15:0] e;
    logic [15:0] obs;
    if (rst_i == 1'b0) begin
      e    = 16'hFFFF;
      m_e  = 0;
      m_sh = '0;
    end else begin
      d    = m_idx();
      rest = m_sh >> (4 * d);
      n    = rest[3:0];
      if (blank_i && d != 0 && rest == 32'd0) e = 16'hFFFF;
      else e = {~(8'd1 << d), seg_tab[n], ~dp_i[d]};
      if (m_e == 0) m_sh = data_i;
      else if ((m_e % FRAME) == FRAME - 1 && !hold_i) m_sh = data_i;
      m_e++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    obs = {an_o, seg_o, dp_o};
    check(phase, obs, exp_q.pop_front());
    checks++;
    assert ($countones(~an_o) <= 1) else begin
      errors++;
      $error("FAIL one_anode: observed an_o %h expected at most one low bit", an_o);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_idx(input int target);
    for (int i = 0; i < FRAME && !(m_idx() == target && (m_e % DIV) == 0); i++) tick();
  endtask

  initial begin
    rst_i   = 1'b0;
    data_i  = 32'h1234ABCD;
    hold_i  = 1'b0;
    blank_i = 1'b0;
    dp_i    = 8'h00;
    @(negedge clk);

    // reset held for three cycles, outputs dark throughout
    phase = "reset";
    run(3);
    rst_i = 1'b1;

    // first edge latches the word, second edge shows digit 0 = D
    phase = "release";
    tick();
    tick();
    check("first_digit", {an_o, seg_o}, {8'hFE, 7'h21});

    phase = "scan";
    run(2 * FRAME);

    // data changes mid-frame; upper digits of this frame keep the old word
    phase = "tear";
    run_to_idx(3);
    data_i = 32'hFFFFFFFF;
    run(FRAME + 5 * DIV);

    // hold freezes the display across three frames of changing data
    phase = "hold";
    run_to_idx(0);
    hold_i = 1'b1;
    for (int f = 0; f < 3; f++) begin
      run(DIV * 3);
      data_i = $urandom;
      run(FRAME - DIV * 3);
    end
    hold_i = 1'b0;
    phase  = "unhold";
    run(2 * FRAME);

    // leading-zero blanking
    phase   = "blank";
    blank_i = 1'b1;
    data_i  = 32'h000000A5;
    run(2 * FRAME);
    data_i  = 32'h00000000;
    run(2 * FRAME);
    blank_i = 1'b0;

    // decimal point on digit 0, then an asynchronous reset mid-slot at digit 5
    phase  = "dp";
    dp_i   = 8'h01;
    data_i = 32'h1234ABCD;
    run(2 * FRAME);
    run_to_idx(5);
    tick();
    #2 rst_i = 1'b0;
    #1 check("async_reset", {an_o, seg_o, dp_o}, 16'hFFFF);
    @(negedge clk);
    phase = "mid_reset";
    m_e   = 0;
    m_sh  = '0;
    run(2);
    rst_i = 1'b1;
    phase = "resume";
    run(2 * FRAME);

    // randomized traffic, biased toward short words to exercise blanking
    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) data_i = $urandom >> (4 * $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0) hold_i = ~hold_i;
      if ($urandom_range(0, 29) == 0) blank_i = ~blank_i;
      if ($urandom_range(0, 29) == 0) dp_i = 8'($urandom);
      if ($urandom_range(0, 199) == 0) rst_i = 1'b0;
      else rst_i = 1'b1;
      tick();
    end
    rst_i = 1'b1;
    run(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cobra_hex_display.md
COBRA_HEX_DISPLAY -- requirements
Module: cobra_hex_display

Interface
REQ-001 SHALL have parameter DIV, default 100000, meaning the number of clk_i cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have port clk_i, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port data_i, input, 32 bits: the processor output word (the CYBERcobra out_o) to display as 8 hex digits.
REQ-005 SHALL have port hold_i, input, 1 bit: 1 freezes the displayed word.
REQ-006 SHALL have port blank_i, input, 1 bit: 1 enables leading-zero blanking.
REQ-007 SHALL have port dp_i, input, 8 bits: decimal-point mask; bit i lights the point of digit i.
REQ-008 SHALL have port an_o, output, 8 bits: active-low digit anodes; bit i selects digit i, where digit 0 is the least significant.
REQ-009 SHALL have port seg_o, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, where bit 0 is a.
REQ-010 SHALL have port dp_o, output, 1 bit: active-low decimal point.

Function
REQ-011 SHALL hold a prescaler pre (0..DIV-1) that increments every cycle and wraps from DIV-1 to 0.
REQ-012 SHALL hold a 3-bit digit index idx that increments, wrapping 7 to 0, only in the cycle where pre==DIV-1.
REQ-013 SHALL hold a 32-bit shadow register sh and a 1-bit init flag, both set by reset (init=1).
REQ-014 SHALL load sh <= data_i in the cycle where init==1, and clear init in that same cycle, regardless of hold_i.
REQ-015 SHALL otherwise load sh <= data_i only at frame wrap (pre==DIV-1 and idx==7) with hold_i==0; a change to data_i mid-frame therefore SHALL NOT be displayed until the next frame, so there is no tearing.
REQ-016 SHALL, when frame wrap occurs with hold_i==1, keep sh unchanged.
REQ-017 SHALL select nibble n = sh[4*idx+3 : 4*idx] for the current digit.
REQ-018 SHALL encode n active-low, in hex order 0..F, as: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-019 SHALL treat digit idx as blank when blank_i==1, idx!=0, and sh[31 : 4*idx]==0; digit 0 SHALL never be blanked.
REQ-020 SHALL register all outputs, so values in cycle t+1 reflect idx, sh and inputs in cycle t.
REQ-021 SHALL drive an_o with only bit idx low when the digit is not blank.
REQ-022 SHALL drive seg_o = encode(n) and dp_o = ~dp_i[idx] when the digit is not blank.
REQ-023 SHALL, when the digit is blank, drive an_o=FF, seg_o=7F and dp_o=1.
REQ-024 SHALL never drive more than one an_o bit low in any cycle.

Reset
REQ-025 SHALL, while rst_i==0, immediately force pre=0, idx=0, sh=0, init=1, an_o=FF, seg_o=7F, dp_o=1, independent of clk_i.
REQ-026 SHALL, on assertion mid-frame, abandon the scan; after release the scan restarts at digit 0 with a full DIV-cycle slot.
REQ-027 SHALL, in the first edge after release, load sh from data_i (init); outputs SHALL show digit 0 of sh from the second edge.

Verification (DIV=4)
REQ-028 SHALL cover reset: rst_i=0 for 3 cycles with data_i=1234ABCD -> an_o=FF, seg_o=7F, dp_o=1 throughout; after release, digit 0 shows D (seg_o=21, an_o=FE).
REQ-029 SHALL cover scan order: data_i=1234ABCD, hold_i=0 -> digits 0..7 show D,C,B,A,4,3,2,1 (seg_o=21,46,03,08,19,30,24,79), each for 4 cycles, with an_o=FE,FD,...,7F, repeating every 32 cycles.
REQ-030 SHALL cover tear-free update: data_i changed to FFFFFFFF while idx==3 -> digits 4..7 still show 4,3,2,1; the next frame shows F (0E) on all digits.
REQ-031 SHALL cover hold: hold_i=1, then data_i changed for 3 frames -> the display is unchanged; hold_i=0 -> the new value appears at the next frame.
REQ-032 SHALL cover blanking: blank_i=1, data_i=000000A5 -> digits 0,1 show 5,A; slots 2..7 give an_o=FF; data_i=0 -> only digit 0 shows 0 (seg_o=40).
REQ-033 SHALL cover decimal point and mid-scan reset: dp_i=01 -> dp_o=0 only in digit-0 slots; rst_i pulsed low at idx==5 -> outputs blank at once, and the scan resumes at digit 0.
